// File: rtl/wb_trace_checker.sv
// Write-back trace checker: buffers golden commits in a FIFO, compares each CPU
// register-file write against the head, and latches pass / first-failure diagnostics.
module wb_trace_checker #(
    parameter int          DEPTH  = 16,
    parameter int          CNT_W  = 32,
    parameter logic [31:0] END_PC = 32'hbfc00100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              debug_wb_pc,
    input  logic [3:0]               debug_wb_rf_wen,
    input  logic [4:0]               debug_wb_rf_wnum,
    input  logic [31:0]              debug_wb_rf_wdata,
    input  logic                     gold_valid,
    output logic                     gold_ready,
    input  logic [31:0]              gold_pc,
    input  logic [4:0]               gold_wnum,
    input  logic [31:0]              gold_wdata,
    output logic                     pass,
    output logic                     fail,
    output logic [2:0]               err_code,
    output logic [31:0]              err_pc,
    output logic [31:0]              err_exp_wdata,
    output logic [31:0]              err_got_wdata,
    output logic [CNT_W-1:0]         commit_cnt,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = DEPTH[AW:0];

    typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_e;

    state_e            state_q, state_d;
    logic [31:0]       mem_pc_q    [DEPTH];
    logic [4:0]        mem_wnum_q  [DEPTH];
    logic [31:0]       mem_wdata_q [DEPTH];
    logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic [2:0]        err_code_q, err_code_d;
    logic [31:0]       err_pc_q, err_exp_q, err_got_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic        full, empty, push, pop, commit;
    logic [31:0] head_pc, head_wdata, wmask;
    logic [4:0]  head_wnum;

    always_comb begin
        full       = (count_q == FULL_CNT);
        empty      = (count_q == '0);
        head_pc    = mem_pc_q[rd_ptr_q];
        head_wnum  = mem_wnum_q[rd_ptr_q];
        head_wdata = mem_wdata_q[rd_ptr_q];
        wmask      = {{8{debug_wb_rf_wen[3]}}, {8{debug_wb_rf_wen[2]}},
                      {8{debug_wb_rf_wen[1]}}, {8{debug_wb_rf_wen[0]}}};
        // Full means not ready even if a pop frees a slot this cycle.
        gold_ready = !reset && (state_q == ST_RUN) && !full;
        push       = gold_valid && gold_ready;
        commit     = (state_q == ST_RUN) && (debug_wb_rf_wen != 4'b0) && (debug_wb_rf_wnum != 5'd0);
        pop        = commit && !empty;
    end

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        err_code_d = 3'd0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        count_d    = count_q;
        if (commit) begin
            if (empty)                                               err_code_d = 3'd4;
            else if (head_pc != debug_wb_pc)                         err_code_d = 3'd1;
            else if (head_wnum != debug_wb_rf_wnum)                  err_code_d = 3'd2;
            else if (((head_wdata ^ debug_wb_rf_wdata) & wmask) != '0) err_code_d = 3'd3;
        end
        if (state_q == ST_RUN) begin
            if (err_code_d != 3'd0) begin
                state_d = ST_FAIL;
            end else begin
                if (pop && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
                if (debug_wb_pc == END_PC) state_d = ST_PASS;
            end
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            err_code_q <= 3'd0;
            err_pc_q   <= '0;
            err_exp_q  <= '0;
            err_got_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if ((state_q == ST_RUN) && (err_code_d != 3'd0)) begin
                err_code_q <= err_code_d;
                err_pc_q   <= debug_wb_pc;
                err_exp_q  <= empty ? 32'd0 : head_wdata;
                err_got_q  <= debug_wb_rf_wdata;
            end
        end
    end

    // NOTE: the storage array has no reset; resetting the pointers and count is enough to empty it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]    <= gold_pc;
            mem_wnum_q[wr_ptr_q]  <= gold_wnum;
            mem_wdata_q[wr_ptr_q] <= gold_wdata;
        end
    end

    assign pass          = (state_q == ST_PASS);
    assign fail          = (state_q == ST_FAIL);
    assign err_code      = err_code_q;
    assign err_pc        = err_pc_q;
    assign err_exp_wdata = err_exp_q;
    assign err_got_wdata = err_got_q;
    assign commit_cnt    = cnt_q;
    assign fifo_count    = count_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Scoreboard bench for wb_trace_checker: a queue-based reference model predicts the
// registered outputs each cycle; a monitor compares them after every clock edge.
module tb_wb_trace_checker;

    localparam int          DEPTH  = 16;
    localparam logic [31:0] END_PC = 32'hbfc00100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] debug_wb_pc = '0;
    logic [3:0]  debug_wb_rf_wen = '0;
    logic [4:0]  debug_wb_rf_wnum = '0;
    logic [31:0] debug_wb_rf_wdata = '0;
    logic        gold_valid = 1'b0;
    logic        gold_ready;
    logic [31:0] gold_pc = '0;
    logic [4:0]  gold_wnum = '0;
    logic [31:0] gold_wdata = '0;
    logic        pass, fail;
    logic [2:0]  err_code;
    logic [31:0] err_pc, err_exp_wdata, err_got_wdata, commit_cnt;
    logic [4:0]  fifo_count;

    wb_trace_checker #(.DEPTH(DEPTH), .CNT_W(32), .END_PC(END_PC)) dut (
        .clk(clk), .reset(reset),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .gold_valid(gold_valid), .gold_ready(gold_ready), .gold_pc(gold_pc),
        .gold_wnum(gold_wnum), .gold_wdata(gold_wdata), .pass(pass), .fail(fail),
        .err_code(err_code), .err_pc(err_pc), .err_exp_wdata(err_exp_wdata),
        .err_got_wdata(err_got_wdata), .commit_cnt(commit_cnt), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        gr, ps, fl;
        bit [2:0]  ec;
        bit [31:0] epc, ew, gw, cnt;
        bit [4:0]  fc;
    } exp_t;

    typedef struct {
        bit [31:0] pc;
        bit [4:0]  wn;
        bit [31:0] wd;
    } gold_t;

    exp_t  exp_q[$];
    gold_t m_q[$];
    int        m_state;   // 0 running, 1 passed, 2 failed
    bit [2:0]  m_ec;
    bit [31:0] m_epc, m_ew, m_gw, m_cnt;
    int        n_checks = 0;
    int        n_err = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: apply the checker rules to the current inputs, queue the
    // expected post-edge outputs, then advance one clock.
    task automatic step();
        exp_t  e;
        gold_t h;
        bit    rdy, pushed, commit;
        int    code;
        bit [31:0] expw;
        if (reset) begin
            m_q.delete();
            m_state = 0; m_ec = 0; m_epc = 0; m_ew = 0; m_gw = 0; m_cnt = 0;
        end else if (m_state == 0) begin
            rdy    = m_q.size() < DEPTH;
            pushed = gold_valid && rdy;
            commit = (debug_wb_rf_wen != 0) && (debug_wb_rf_wnum != 0);
            code   = 0;
            expw   = 0;
            if (commit) begin
                if (m_q.size() == 0) begin
                    code = 4;
                end else begin
                    h    = m_q.pop_front();
                    expw = h.wd;
                    if (h.pc != debug_wb_pc) code = 1;
                    else if (h.wn != debug_wb_rf_wnum) code = 2;
                    else
                        for (int b = 0; b < 4; b++)
                            if (debug_wb_rf_wen[b] && (h.wd[8*b +: 8] != debug_wb_rf_wdata[8*b +: 8]))
                                code = 3;
                end
            end
            if (pushed) m_q.push_back('{gold_pc, gold_wnum, gold_wdata});
            if (code != 0) begin
                m_state = 2; m_ec = 3'(code); m_epc = debug_wb_pc; m_ew = expw; m_gw = debug_wb_rf_wdata;
            end else begin
                if (commit && m_cnt != 32'hffffffff) m_cnt++;
                if (debug_wb_pc == END_PC) m_state = 1;
            end
        end
        e.gr  = !reset && (m_state == 0) && (m_q.size() < DEPTH);
        e.ps  = (m_state == 1);
        e.fl  = (m_state == 2);
        e.ec  = m_ec;
        e.epc = m_epc;
        e.ew  = m_ew;
        e.gw  = m_gw;
        e.cnt = m_cnt;
        e.fc  = 5'(m_q.size());
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic drv(bit gv, bit [31:0] gpc, bit [4:0] gwn, bit [31:0] gwd,
                       bit [3:0] wen, bit [4:0] wn, bit [31:0] wd, bit [31:0] pc);
        gold_valid = gv; gold_pc = gpc; gold_wnum = gwn; gold_wdata = gwd;
        debug_wb_rf_wen = wen; debug_wb_rf_wnum = wn; debug_wb_rf_wdata = wd; debug_wb_pc = pc;
        step();
    endtask

    task automatic push(bit [31:0] gpc, bit [4:0] gwn, bit [31:0] gwd);
        drv(1, gpc, gwn, gwd, 0, 0, 0, 0);
    endtask

    task automatic commit(bit [31:0] pc, bit [4:0] wn, bit [31:0] wd, bit [3:0] wen);
        drv(0, 0, 0, 0, wen, wn, wd, pc);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
    endtask

    // Commit a correct copy of the model's head, optionally offering a push too.
    task automatic commit_head(bit gv, bit [31:0] gpc, bit [4:0] gwn, bit [31:0] gwd);
        gold_t h = m_q[0];
        drv(gv, gpc, gwn, gwd, 4'hF, h.wn, h.wd, h.pc);
    endtask

    exp_t me;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            me = exp_q.pop_front();
            check("gold_ready", 32'(gold_ready), 32'(me.gr));
            check("pass", 32'(pass), 32'(me.ps));
            check("fail", 32'(fail), 32'(me.fl));
            check("err_code", 32'(err_code), 32'(me.ec));
            check("err_pc", err_pc, me.epc);
            check("err_exp_wdata", err_exp_wdata, me.ew);
            check("err_got_wdata", err_got_wdata, me.gw);
            check("commit_cnt", commit_cnt, me.cnt);
            check("fifo_count", 32'(fifo_count), 32'(me.fc));
        end
    end

    initial begin
        bit [31:0] gpc, gwd, cpc, cwd;
        bit [4:0]  gwn, cwn;
        bit [3:0]  cwen;
        gold_t     h;

        do_reset();
        idle(1);

        // Three in-order matching commits
        push(32'hbfc00000, 5'd1, 32'h11);
        push(32'hbfc00004, 5'd2, 32'h22);
        push(32'hbfc00008, 5'd3, 32'h33);
        commit(32'hbfc00000, 5'd1, 32'h11, 4'hF);
        commit(32'hbfc00004, 5'd2, 32'h22, 4'hF);
        commit(32'hbfc00008, 5'd3, 32'h33, 4'hF);
        idle(1);

        // Byte-masked match, then a full-word data mismatch
        push(32'hbfc0000c, 5'd6, 32'hAABBCCDD);
        commit(32'hbfc0000c, 5'd6, 32'h0000CCDD, 4'b0011);
        push(32'hbfc00010, 5'd7, 32'h12345678);
        commit(32'hbfc00010, 5'd7, 32'h12345679, 4'hF);
        drv(1, 32'h1, 5'd1, 32'h1, 0, 0, 0, 0);
        idle(1);
        do_reset();

        // PC mismatch outranks wnum and data
        push(32'hbfc00010, 5'd4, 32'h1);
        commit(32'hbfc00014, 5'd5, 32'h2, 4'hF);
        idle(1);
        do_reset();

        // r0 writes and wen==0 do not pop; then underflow with a same-cycle push
        push(32'hbfc00020, 5'd9, 32'h99);
        commit(32'hbfc00020, 5'd0, 32'h99, 4'hF);
        commit(32'hbfc00020, 5'd9, 32'h99, 4'h0);
        commit(32'hbfc00020, 5'd9, 32'h99, 4'hF);
        drv(1, 32'hbfc00024, 5'd7, 32'h77, 4'hF, 5'd7, 32'h77, 32'hbfc00024);
        idle(1);
        do_reset();

        // Fill, hold while full, pop with gold_valid high, wrap through 20 entries
        for (int i = 0; i < 16; i++) push(32'hbfc00000 + 32'(4*i), 5'((i % 31) + 1), 32'(i) * 32'h01010101);
        drv(1, 32'hbfc00040, 5'd17, 32'h10101010, 0, 0, 0, 0);
        commit_head(1, 32'hbfc00040, 5'd17, 32'h10101010);
        for (int i = 16; i < 20; i++) commit_head(1, 32'hbfc00000 + 32'(4*i), 5'((i % 31) + 1), 32'(i) * 32'h01010101);
        while (m_q.size() != 0) commit_head(0, 0, 0, 0);
        idle(1);
        do_reset();

        // End PC with entries left, later mismatch ignored, reset clears sticky pass
        for (int i = 0; i < 7; i++) push(32'hbfc00000 + 32'(4*i), 5'(i + 1), 32'(i) + 32'h100);
        commit_head(0, 0, 0, 0);
        commit_head(0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, END_PC);
        commit(32'hdead0000, 5'd3, 32'h5, 4'hF);
        do_reset();
        idle(1);

        // Randomised traffic against the model
        for (int it = 0; it < 1500; it++) begin
            if ((m_state != 0 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
                do_reset();
                continue;
            end
            gpc = 32'hbfc00000 + ($urandom_range(0, 255) << 2);
            gwn = 5'($urandom_range(1, 31));
            gwd = $urandom;
            cpc = ($urandom_range(0, 49) == 0) ? END_PC : 32'hbfc00000 + ($urandom_range(0, 255) << 2);
            cwen = 4'h0; cwn = 5'd0; cwd = $urandom;
            if ($urandom_range(0, 9) < 4) begin
                cwen = 4'($urandom_range(1, 15));
                if (m_q.size() != 0) begin
                    h   = m_q[0];
                    cpc = h.pc;
                    cwn = h.wn;
                    for (int b = 0; b < 4; b++) if (cwen[b]) cwd[8*b +: 8] = h.wd[8*b +: 8];
                    case ($urandom_range(0, 29))
                        0: cpc = cpc ^ 32'h4;
                        1: cwn = (cwn == 5'd31) ? 5'd30 : cwn + 5'd1;
                        2: cwd = cwd ^ {{8{cwen[3]}}, {8{cwen[2]}}, {8{cwen[1]}}, {8{cwen[0]}}};
                        default: ;
                    endcase
                end else begin
                    cwn = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                end
            end else if ($urandom_range(0, 3) == 0) begin
                cwen = 4'($urandom_range(1, 15));
                cwn  = 5'd0;
            end
            drv(1'($urandom_range(0, 1)), gpc, gwn, gwd, cwen, cwn, cwd, cpc);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_trace_checker.md
Name: wb_trace_checker

Overview:
- Receiving end of the CPU write-back trace debug interface (debug_wb_pc / debug_wb_rf_wen / debug_wb_rf_wnum / debug_wb_rf_wdata).
- Buffers golden trace entries pushed by the testbench through a valid/ready FIFO.
- Compares each CPU register-file commit against the FIFO head, flags the first mismatch with sticky diagnostics, and declares pass when the CPU reaches the end PC.
- Sits beside mycpu_top in the simulation/FPGA test harness.

Parameters:
- DEPTH, 16, golden FIFO entries; power of 2, ≥2.
- CNT_W, 32, width of the commit counter.
- END_PC, 32'hbfc00100, PC value that ends the test.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- debug_wb_pc  in  32  PC of the instruction in WB
- debug_wb_rf_wen  in  4  byte write enables of the RF write
- debug_wb_rf_wnum  in  5  destination register
- debug_wb_rf_wdata  in  32  write data
- gold_valid  in  1  golden entry offered
- gold_ready  out  1  FIFO accepts the entry
- gold_pc  in  32  expected PC
- gold_wnum  in  5  expected destination register
- gold_wdata  in  32  expected write data
- pass  out  1  sticky; END_PC reached with no error
- fail  out  1  sticky; first error detected
- err_code  out  3  0 none, 1 PC, 2 WNUM, 3 WDATA, 4 underflow
- err_pc  out  32  debug_wb_pc of the failing commit
- err_exp_wdata  out  32  golden wdata of the failing commit (0 on underflow)
- err_got_wdata  out  32  CPU wdata of the failing commit
- commit_cnt  out  CNT_W  number of matched commits
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: state RUN, FIFO empty, all outputs 0 (gold_ready = 0 during the reset cycle, then 1).
- Reset mid-test clears everything, including sticky pass/fail and FIFO contents.
- State machine states: RUN, PASS, FAIL.
  - PASS and FAIL are absorbing until reset.
  - In PASS and FAIL: gold_ready = 0, no pushes, no pops, commit_cnt frozen.
- Push rule: gold_ready = (state==RUN) && (fifo_count < DEPTH).
  - A push occurs when gold_valid && gold_ready.
  - Full FIFO holds gold_ready low even if a pop happens in the same cycle; no same-cycle full replacement.
- Commit definition: state==RUN && debug_wb_rf_wen != 4'b0 && debug_wb_rf_wnum != 0. Writes to r0 and wen==0 cycles are ignored.
- On commit with FIFO non-empty:
  - Pop the head.
  - Compare in priority order PC > WNUM > WDATA.
  - WDATA compare is masked per byte by debug_wb_rf_wen; only enabled bytes are compared.
  - All match: commit_cnt += 1, saturating at all-ones.
  - Any mismatch: next state FAIL, fail=1, err_code set, err_pc / err_exp_wdata / err_got_wdata latched from that cycle. commit_cnt is not incremented.
- On commit with FIFO empty: FAIL, err_code=4, err_exp_wdata=0. No same-cycle push bypass; an entry pushed in the same cycle does not satisfy that commit.
- Simultaneous push and pop when not full: both occur, and fifo_count is unchanged.
- End detection: in RUN, debug_wb_pc == END_PC on any cycle with no error in that cycle → PASS, pass=1.
  - If that same cycle also carries a failing commit, FAIL wins.
  - A matching commit in that same cycle is counted before entering PASS.
- FIFO pointers wrap modulo DEPTH.
- Latency:
  - Errors and pass are registered; pass/fail rise the cycle after the triggering cycle.
  - gold_ready and fifo_count reflect registered state.
- Remaining golden entries at PASS are not an error.

Test Plan:
- Match: push 3 entries (bfc00000, r1, 0x11), (bfc00004, r2, 0x22), (bfc00008, r3, 0x33); drive 3 matching commits → commit_cnt=3, fail=0, fifo_count=0.
- Data mismatch with mask: golden wdata 0xAABBCCDD, CPU writes wen=4'b0011, wdata 0x0000CCDD → match. Then golden 0x12345678 vs CPU 0x12345679 with wen=4'hF → next cycle fail=1, err_code=3, err_exp_wdata=0x12345678, err_got_wdata=0x12345679, and gold_ready=0 afterward.
- PC priority: golden (bfc00010, r4, 0x1); CPU commits pc bfc00014, r5, 0x2 → err_code=1, err_pc=bfc00014.
- Underflow: empty FIFO, CPU commits r7 with gold_valid pushing in the same cycle → err_code=4. Also verify that r0 writes and wen=0 cycles are ignored and do not pop.
- Full FIFO: push 16 entries → gold_ready=0 and fifo_count=16. A commit pop in a cycle with gold_valid=1 accepts no push that cycle; gold_ready rises the next cycle. Push 20 total across pops to confirm pointer wrap and in-order compare.
- End and reset: 2 matched commits, then debug_wb_pc=bfc00100 → pass=1 with 5 entries left. Inject a mismatching commit → fail stays 0. Assert reset for 1 cycle → pass=0, fifo_count=0, commit_cnt=0.
